v_issue_seq: RTL and testbench
==============================

# v_issue_seq

Vector issue sequencer. Sits directly downstream of the vector decoder. It accepts one decoded vector instruction at a time through a valid/ready handshake and holds the current vector length (vl), which it updates on vconfig instructions. It breaks each arithmetic, multiply, reduction, slide or load/store instruction into LANES-wide element beats for the execution units, with a per-beat lane mask and a last-beat flag.

## Interface
Parameters:
- LANES, default 4: elements issued per beat. Power of two, 1 to 16.
- VLMAX, default 32: maximum vl in elements. Must be a multiple of LANES.
- VLW, default $clog2(VLMAX+1): width of vl and element indices. Derived; do not override.

Ports:
- clk  in  1  clock. One clock domain only.
- nrst  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  1  a decoded instruction is presented.
- in_ready  out  1  sequencer accepts the instruction presented this cycle.
- is_vconfig  in  1  decoded vconfig flag.
- v_alu_op  in  4  ALU opcode; 0 means none.
- is_mul  in  1  multiply flag.
- v_red_op  in  3  reduction opcode; 0 means none.
- v_sldu_op  in  3  slide/move opcode; 0 means none.
- v_lsu_op  in  4  load/store opcode; 0 means none.
- vd, vs1, vs2  in  5 each  register indices (instr[11:7], [19:15], [24:20]).
- avl  in  32  requested application vector length (rs1 value); used only for vconfig.
- vl  out  VLW  current vector length.
- iss_valid  out  1  an issue beat is presented.
- iss_ready  in  1  the execution side accepts the beat.
- iss_unit  out  3  target unit: 1 ALU, 2 MUL, 3 RED, 4 SLDU, 5 LSU; 0 when idle.
- iss_op  out  4  unit opcode, zero-extended from the selected input field; 1 for MUL.
- iss_vd, iss_vs1, iss_vs2  out  5 each  latched register indices.
- iss_elem_base  out  VLW  index of the first element in the beat.
- iss_elem_mask  out  LANES  bit i set when iss_elem_base+i < vl.
- iss_last  out  1  the beat is the final beat of the instruction.
- busy  out  1  high in the ISSUE state.

## Operation
- FSM with two states, IDLE and ISSUE. Reset puts it in IDLE.
- In IDLE, in_ready=1. In ISSUE, in_ready=0.
- An instruction is accepted on any cycle where in_valid && in_ready. Its result depends on the decoded fields:
  - is_vconfig=1: vl <= min(avl, VLMAX), compared as unsigned 32-bit. State stays IDLE. No beat is issued.
  - Otherwise the unit is selected by priority LSU > SLDU > RED > MUL > ALU, using the first field that is nonzero. The sequencer latches the unit, the opcode, the register indices and base=0.
  - If no unit field is nonzero, the instruction is consumed and dropped. State stays IDLE.
  - If vl==0, the instruction is consumed and no beat is issued. State stays IDLE.
  - Any other instruction moves the FSM to ISSUE.
- vl is read at accept time. vl cannot change while the FSM is in ISSUE.
- In ISSUE:
  - iss_valid=1.
  - iss_last = (base+LANES >= vl).
  - Each beat transfers when iss_valid && iss_ready.
  - On transfer of a beat that is not last: base += LANES.
  - On transfer of the last beat: go to IDLE and clear iss_unit, iss_op and base.
- Number of beats = ceil(vl/LANES). Base arithmetic is VLW+1 bits wide, so it never wraps.
- While iss_valid=1 and iss_ready=0, every iss_* output holds stable.

## Timing
- Reset values: vl=0, in_ready=1 (IDLE), iss_valid=0, iss_unit=0, iss_op=0, iss_vd=0, iss_vs1=0, iss_vs2=0, iss_elem_base=0, iss_elem_mask=0, iss_last=0, busy=0.
- Asserting nrst mid-instruction drops iss_valid asynchronously and discards the instruction.
- Outputs are driven from registers. The only exceptions are in_ready, which is decoded from the state, and iss_elem_mask and iss_last, which are decoded from registered base and vl.
- Instruction accepted in cycle N: the first beat is valid in cycle N+1.
- With iss_ready held at 1, beats arrive back-to-back, one per cycle.
- Last beat transfers in cycle M: in_ready=1 in cycle M+1. The gap between instructions is one cycle.
- vconfig accepted in cycle N: the new vl is visible in cycle N+1. An arithmetic instruction accepted in cycle N+1 uses the new vl.

## Test plan
- vconfig avl=10, then vadd (v_alu_op=1, vd=3): three beats with base 0, 4, 8, masks 1111, 1111, 0011, iss_last only on the third beat, iss_unit=1, iss_op=1, iss_vd=3.
- vconfig avl=100: vl=32. A vlse16 (v_lsu_op=5) with v_alu_op also nonzero issues 8 beats, iss_unit=5, iss_op=5, every mask 1111.
- Toggle iss_ready 0,1,0,0,1 during a vl=10 vmul: all iss_* outputs stay stable through stalls, three beats total, in_ready=0 until the cycle after the last transfer.
- vconfig avl=0, then vredsum: instruction accepted, iss_valid never rises, in_ready stays 1. An all-zero-op instruction is also consumed silently.
- Assert nrst on the second beat of a vl=16 instruction: iss_valid=0 immediately, vl=0 and in_ready=1 after release, and no further beats appear.
- Back-to-back vconfig avl=5 then vslideup at cycle N+1: the slide uses vl=5 and issues two beats with masks 1111 and 0001.

Source files
------------

// File: rtl/v_issue_seq.sv
// v_issue_seq: vector issue sequencer.
// Takes one decoded vector instruction at a time over a valid/ready handshake.
// It holds the current vector length (vl) and updates it on vconfig.
// It breaks each unit instruction into LANES-wide element beats for the execution side.
//
// Ports:
//   clk, nrst                   clock; asynchronous active-low reset
//   in_valid / in_ready         instruction handshake (ready only in IDLE)
//   is_vconfig, avl             vconfig flag and requested vector length
//   v_alu_op, is_mul, v_red_op,
//   v_sldu_op, v_lsu_op         decoded unit fields (0 = none)
//   vd, vs1, vs2                register indices
//   vl                          current vector length
//   iss_valid / iss_ready       beat handshake
//   iss_unit, iss_op            target unit (1 ALU..5 LSU) and its opcode
//   iss_vd, iss_vs1, iss_vs2    latched register indices
//   iss_elem_base               index of first element in the beat
//   iss_elem_mask               per-lane active mask (base+i < vl)
//   iss_last                    final beat of the instruction
//   busy                        sequencer is issuing beats
module v_issue_seq #(
    parameter int LANES = 4,
    parameter int VLMAX = 32,
    parameter int VLW   = $clog2(VLMAX + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_vconfig,
    input  logic [3:0]       v_alu_op,
    input  logic             is_mul,
    input  logic [2:0]       v_red_op,
    input  logic [2:0]       v_sldu_op,
    input  logic [3:0]       v_lsu_op,
    input  logic [4:0]       vd,
    input  logic [4:0]       vs1,
    input  logic [4:0]       vs2,
    input  logic [31:0]      avl,
    output logic [VLW-1:0]   vl,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [2:0]       iss_unit,
    output logic [3:0]       iss_op,
    output logic [4:0]       iss_vd,
    output logic [4:0]       iss_vs1,
    output logic [4:0]       iss_vs2,
    output logic [VLW-1:0]   iss_elem_base,
    output logic [LANES-1:0] iss_elem_mask,
    output logic             iss_last,
    output logic             busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t         state, state_d;
    logic [VLW-1:0] vl_q;
    logic [VLW:0]   base_q;
    logic [VLW:0]   base_next;
    logic [2:0]     unit_q;
    logic [3:0]     op_q;
    logic [4:0]     vd_q, vs1_q, vs2_q;

    logic [2:0]     sel_unit;
    logic [3:0]     sel_op;
    logic           accept;
    logic           start;
    logic           beat_fire;
    logic           last_hit;

    // Unit priority: LSU > SLDU > RED > MUL > ALU.
    always_comb begin
        sel_unit = '0;
        sel_op   = '0;
        if (v_lsu_op != '0) begin
            sel_unit = 3'd5;
            sel_op   = v_lsu_op;
        end else if (v_sldu_op != '0) begin
            sel_unit = 3'd4;
            sel_op   = {1'b0, v_sldu_op};
        end else if (v_red_op != '0) begin
            sel_unit = 3'd3;
            sel_op   = {1'b0, v_red_op};
        end else if (is_mul) begin
            sel_unit = 3'd2;
            sel_op   = 4'd1;
        end else if (v_alu_op != '0) begin
            sel_unit = 3'd1;
            sel_op   = v_alu_op;
        end
    end

    // accept is decoded from state directly, not via in_ready, to keep the
    // handshake free of a combinational path through the FSM output block.
    assign accept    = in_valid && (state == IDLE);
    assign start     = accept && !is_vconfig && (sel_unit != '0) && (vl_q != '0);
    assign base_next = base_q + (VLW + 1)'(LANES);
    assign last_hit  = base_next >= {1'b0, vl_q};
    assign beat_fire = (state == ISSUE) && iss_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        iss_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                iss_valid = 1'b1;
                busy      = 1'b1;
                if (beat_fire && last_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vl_q   <= '0;
            base_q <= '0;
            unit_q <= '0;
            op_q   <= '0;
            vd_q   <= '0;
            vs1_q  <= '0;
            vs2_q  <= '0;
        end else begin
            if (accept && is_vconfig) begin
                vl_q <= (avl > 32'(VLMAX)) ? VLW'(VLMAX) : avl[VLW-1:0];
            end
            if (start) begin
                unit_q <= sel_unit;
                op_q   <= sel_op;
                vd_q   <= vd;
                vs1_q  <= vs1;
                vs2_q  <= vs2;
                base_q <= '0;
            end else if (beat_fire) begin
                if (last_hit) begin
                    unit_q <= '0;
                    op_q   <= '0;
                    base_q <= '0;
                end else begin
                    base_q <= base_next;
                end
            end
        end
    end

    always_comb begin
        iss_elem_mask = '0;
        if (state == ISSUE) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                iss_elem_mask[i] = (base_q + (VLW + 1)'(i)) < {1'b0, vl_q};
            end
        end
    end

    assign iss_last      = (state == ISSUE) && last_hit;
    assign vl            = vl_q;
    assign iss_unit      = unit_q;
    assign iss_op        = op_q;
    assign iss_vd        = vd_q;
    assign iss_vs1       = vs1_q;
    assign iss_vs2       = vs2_q;
    assign iss_elem_base = base_q[VLW-1:0];

endmodule

// File: tb/tb_v_issue_seq.sv
// Testbench for v_issue_seq (default LANES=4, VLMAX=32).
// A reference model turns each instruction into the expected beats and puts them in a queue.
// The queue entries are popped as beats transfer.
module tb_v_issue_seq;

    localparam int LANES = 4;
    localparam int VLMAX = 32;
    localparam int VLW   = 6;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             is_vconfig = 1'b0;
    logic [3:0]       v_alu_op = '0;
    logic             is_mul = 1'b0;
    logic [2:0]       v_red_op = '0;
    logic [2:0]       v_sldu_op = '0;
    logic [3:0]       v_lsu_op = '0;
    logic [4:0]       vd = '0, vs1 = '0, vs2 = '0;
    logic [31:0]      avl = '0;
    logic [VLW-1:0]   vl;
    logic             iss_valid;
    logic             iss_ready = 1'b0;
    logic [2:0]       iss_unit;
    logic [3:0]       iss_op;
    logic [4:0]       iss_vd, iss_vs1, iss_vs2;
    logic [VLW-1:0]   iss_elem_base;
    logic [LANES-1:0] iss_elem_mask;
    logic             iss_last;
    logic             busy;

    v_issue_seq #(.LANES(LANES), .VLMAX(VLMAX)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .is_vconfig(is_vconfig), .v_alu_op(v_alu_op), .is_mul(is_mul),
        .v_red_op(v_red_op), .v_sldu_op(v_sldu_op), .v_lsu_op(v_lsu_op),
        .vd(vd), .vs1(vs1), .vs2(vs2), .avl(avl), .vl(vl),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_unit(iss_unit),
        .iss_op(iss_op), .iss_vd(iss_vd), .iss_vs1(iss_vs1), .iss_vs2(iss_vs2),
        .iss_elem_base(iss_elem_base), .iss_elem_mask(iss_elem_mask),
        .iss_last(iss_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       unit;
        logic [3:0]       op;
        logic [4:0]       vd;
        logic [4:0]       vs1;
        logic [4:0]       vs2;
        logic [VLW-1:0]   base;
        logic [LANES-1:0] mask;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    m_vl = 0;

    function automatic beat_t cur_beat();
        beat_t b;
        b.unit = iss_unit;
        b.op   = iss_op;
        b.vd   = iss_vd;
        b.vs1  = iss_vs1;
        b.vs2  = iss_vs2;
        b.base = iss_elem_base;
        b.mask = iss_elem_mask;
        b.last = iss_last;
        return b;
    endfunction

    // Drive one instruction for one cycle, update the model and queue the expected beats.
    task automatic send(input logic vcfg, input logic [3:0] alu, input logic mul,
                        input logic [2:0] red, input logic [2:0] sldu, input logic [3:0] lsu,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] a);
        logic [2:0] u;
        logic [3:0] o;
        int nb;
        beat_t b;
        in_valid = 1'b1; is_vconfig = vcfg; v_alu_op = alu; is_mul = mul;
        v_red_op = red; v_sldu_op = sldu; v_lsu_op = lsu;
        vd = d; vs1 = s1; vs2 = s2; avl = a;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL send_in_ready got=%b want=1", in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; is_vconfig = 1'b0; v_alu_op = '0; is_mul = 1'b0;
        v_red_op = '0; v_sldu_op = '0; v_lsu_op = '0; avl = '0;
        if (vcfg) begin
            m_vl = (a > 32'(VLMAX)) ? VLMAX : int'(a);
        end else begin
            u = 3'd0; o = 4'd0;
            if (lsu != 0)       begin u = 3'd5; o = lsu; end
            else if (sldu != 0) begin u = 3'd4; o = {1'b0, sldu}; end
            else if (red != 0)  begin u = 3'd3; o = {1'b0, red}; end
            else if (mul)       begin u = 3'd2; o = 4'd1; end
            else if (alu != 0)  begin u = 3'd1; o = alu; end
            if (u != 0 && m_vl != 0) begin
                nb = (m_vl + LANES - 1) / LANES;
                for (int k = 0; k < nb; k++) begin
                    b.unit = u; b.op = o; b.vd = d; b.vs1 = s1; b.vs2 = s2;
                    b.base = VLW'(k * LANES);
                    for (int i = 0; i < LANES; i++) b.mask[i] = (k * LANES + i) < m_vl;
                    b.last = (k == nb - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Consume queued beats; bit c of pat is iss_ready in cycle c (1 beyond bit 31).
    task automatic drain(input logic [31:0] pat);
        beat_t exp_b, snap;
        logic  stalled = 1'b0;
        int    c = 0;
        while (exp_q.size() != 0 && c < 64) begin
            iss_ready = (c < 32) ? pat[c] : 1'b1;
            @(negedge clk);
            total_cnt++;
            if (iss_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL drain_valid cyc=%0d got valid=%b in_ready=%b want 1/0", c, iss_valid, in_ready);
            else pass_cnt++;
            if (stalled) begin
                total_cnt++;
                if (cur_beat() !== snap)
                    $display("FAIL stall_hold got=%h want=%h", cur_beat(), snap);
                else pass_cnt++;
            end
            if (iss_ready) begin
                exp_b = exp_q.pop_front();
                total_cnt++;
                if (cur_beat() !== exp_b)
                    $display("FAIL beat got=%h want=%h", cur_beat(), exp_b);
                else pass_cnt++;
                stalled = 1'b0;
            end else begin
                snap = cur_beat();
                stalled = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
        end
        iss_ready = 1'b0;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        total_cnt++;
        if (iss_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL after_last got valid=%b in_ready=%b busy=%b want 0/1/0", iss_valid, in_ready, busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vl(input int want);
        @(negedge clk);
        total_cnt++;
        if (vl !== VLW'(want)) $display("FAIL vl got=%0d want=%0d", vl, want);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({vl, in_ready, iss_valid, cur_beat(), busy} !== {VLW'(0), 1'b1, 1'b0, beat_t'(0), 1'b0})
            $display("FAIL reset got=%h want=%h", {vl, in_ready, iss_valid, cur_beat(), busy},
                     {VLW'(0), 1'b1, 1'b0, beat_t'(0), 1'b0});
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd10);
        check_vl(10);
        send(0, 4'd1, 0, 0, 0, 0, 5'd3, 5'd1, 5'd2, 0);
        drain(32'hFFFF_FFFF);
    endtask

    task automatic test_lsu_priority();
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd100);
        check_vl(32);
        send(0, 4'd7, 1, 3'd2, 0, 4'd5, 5'd8, 5'd9, 5'd10, 0);
        drain(32'hFFFF_FFFF);
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        check_vl(32);
    endtask

    task automatic test_stall();
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd10);
        send(0, 4'd2, 1, 0, 0, 0, 5'd4, 5'd5, 5'd6, 0);
        drain(32'hFFFF_FFF2);
    endtask

    task automatic test_zero_vl();
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        send(0, 0, 0, 3'd1, 0, 0, 5'd1, 5'd2, 5'd3, 0);
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd8);
        send(0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0);
        iss_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (iss_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL silent_drop got valid=%b in_ready=%b want 0/1", iss_valid, in_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        iss_ready = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL silent_queue got=%0d want=0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        beat_t exp_b;
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd16);
        send(0, 4'd3, 0, 0, 0, 0, 5'd7, 5'd8, 5'd9, 0);
        iss_ready = 1'b1;
        @(negedge clk);
        exp_b = exp_q.pop_front();
        total_cnt++;
        if (iss_valid !== 1'b1 || cur_beat() !== exp_b)
            $display("FAIL rst_beat0 got=%b/%h want=1/%h", iss_valid, cur_beat(), exp_b);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (iss_valid !== 1'b1 || iss_elem_base !== VLW'(4))
            $display("FAIL rst_beat1 got=%b/%0d want=1/4", iss_valid, iss_elem_base);
        else pass_cnt++;
        nrst = 1'b0;
        #1;
        total_cnt++;
        if (iss_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_async got valid=%b busy=%b want 0/0", iss_valid, busy);
        else pass_cnt++;
        exp_q.delete();
        m_vl = 0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (vl !== VLW'(0) || in_ready !== 1'b1)
            $display("FAIL rst_release got vl=%0d in_ready=%b want 0/1", vl, in_ready);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total_cnt++;
            if (iss_valid !== 1'b0) $display("FAIL rst_nobeat got=%b want=0", iss_valid);
            else pass_cnt++;
        end
        iss_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5);
        send(0, 0, 0, 0, 3'd2, 0, 5'd11, 5'd12, 5'd13, 0);
        drain(32'hFFFF_FFFF);
        send(0, 4'd9, 0, 0, 0, 0, 5'd31, 5'd30, 5'd29, 0);
        drain(32'hFFFF_FFFF);
    endtask

    initial begin
        #1;
        test_reset();
        test_alu();
        test_lsu_priority();
        test_stall();
        test_zero_vl();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
